// File: rtl/invader_formation.sv
// invader_formation: marching invader grid with bullet collision, edge bounce
// and descent, plus cleared/landed terminal states.
// Optional build macro INVADER_SPEEDUP_EN: step period shrinks with level as
// max(STEP_TICKS >> level, 1). Without it the period is always STEP_TICKS.
module invader_formation #(
  parameter int COLS        = 20,
  parameter int ROWS        = 2,
  parameter int STEP_TICKS  = 7200000,
  parameter int BOTTOM_LINE = 14,
  parameter int XW          = 5,
  parameter int YW          = 4
) (
  input  logic                                   clk_36MHz,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   bullet_valid,
  input  logic [XW-1:0]                          bullet_x,
  input  logic [YW-1:0]                          bullet_y,
  input  logic [2:0]                             level,
  output logic                                   hit,
  output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] hit_row,
  output logic [ROWS*COLS-1:0]                   invaders_array,
  output logic [YW-1:0]                          invaders_line,
  output logic                                   cleared,
  output logic                                   landed
);

  localparam int HRW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  // each row starts with its low half populated
  localparam logic [COLS-1:0] ROW_INIT = (COLS'(1) << (COLS / 2)) - COLS'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MARCH   = 2'd1,
    S_CLEARED = 2'd2,
    S_LANDED  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [COLS-1:0] rows_q [ROWS];
  logic [COLS-1:0] rows_d [ROWS];
  logic [YW-1:0]   line_q, line_d;
  logic            dir_q, dir_d;      // 0 = moving left (toward MSB), 1 = moving right
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pend_q, pend_d;    // step deferred because a hit won the cycle
  logic            hit_q, hit_d;
  logic [HRW-1:0]  hit_row_q, hit_row_d;

  // ---------------------------------------------------------------------------
  // step period selection
  // ---------------------------------------------------------------------------
  logic [31:0] period;
`ifdef INVADER_SPEEDUP_EN
  // faster march at higher levels, never below one cycle
  always_comb begin
    period = 32'(STEP_TICKS) >> level;
    if (period == 32'd0) period = 32'd1;
  end
`else
  logic unused_level;
  assign unused_level = ^level;
  // fixed march speed
  always_comb begin
    period = 32'(STEP_TICKS);
  end
`endif

  // >= rather than == so a mid-count level change cannot strand the counter
  logic step_tick;
  assign step_tick = (32'(cnt_q) >= (period - 32'd1));

  // ---------------------------------------------------------------------------
  // per-row observations: edge occupancy and bullet collision
  // ---------------------------------------------------------------------------
  logic [ROWS-1:0] row_left_bit;
  logic [ROWS-1:0] row_right_bit;
  logic [ROWS-1:0] row_hit;
  logic [ROWS-1:0] row_nonzero;
  logic            bx_ok;

  assign bx_ok = (32'(bullet_x) < 32'(COLS));

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_row
      logic [YW:0]     row_line_ext;  // one extra bit so line+r+1 never wraps
      logic [COLS-1:0] shifted;
      assign row_line_ext      = {1'b0, line_q} + (YW+1)'(gi + 1);
      assign shifted           = rows_q[gi] >> bullet_x;
      assign row_left_bit[gi]  = rows_q[gi][COLS-1];
      assign row_right_bit[gi] = rows_q[gi][0];
      assign row_nonzero[gi]   = |rows_q[gi];
      assign row_hit[gi]       = bullet_valid && bx_ok &&
                                 ({1'b0, bullet_y} == row_line_ext) && shifted[0];
      assign invaders_array[gi*COLS +: COLS] = rows_q[gi];
    end
  endgenerate

  logic left_edge, right_edge, all_clear, hit_any, landed_now;
  assign left_edge  = |row_left_bit;
  assign right_edge = |row_right_bit;
  assign all_clear  = ~|row_nonzero;
  assign hit_any    = |row_hit;
  assign landed_now = (({1'b0, line_q} + (YW+1)'(ROWS - 1)) >= (YW+1)'(BOTTOM_LINE));

  // lowest row that the bullet touches (at most one can match a given line)
  logic [HRW-1:0] hit_idx;
  always_comb begin
    hit_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (row_hit[i]) hit_idx = HRW'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // next-state: start/re-init, terminal detection, hit vs step arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    logic do_step;
    state_d   = state_q;
    rows_d    = rows_q;
    line_d    = line_q;
    dir_d     = dir_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    hit_d     = 1'b0;
    hit_row_d = hit_row_q;
    do_step   = 1'b0;

    case (state_q)
      S_MARCH: begin
        if (all_clear) begin
          state_d = S_CLEARED;
        end else if (landed_now) begin
          state_d = S_LANDED;
        end else begin
          cnt_d   = step_tick ? '0 : cnt_q + 1'b1;
          do_step = step_tick || pend_q;
          if (hit_any) begin
            // hit wins; any step due now waits for the next free cycle
            for (int i = 0; i < ROWS; i++) begin
              if (HRW'(i) == hit_idx) begin
                rows_d[i] = rows_q[i] & ~(COLS'(1) << bullet_x);
              end
            end
            hit_d     = 1'b1;
            hit_row_d = hit_idx;
            pend_d    = do_step;
          end else begin
            pend_d = 1'b0;
            if (do_step) begin
              if (!dir_q) begin
                if (left_edge) begin
                  line_d = line_q + 1'b1;
                  dir_d  = 1'b1;
                end else begin
                  for (int i = 0; i < ROWS; i++) rows_d[i] = rows_q[i] << 1;
                end
              end else begin
                if (right_edge) begin
                  line_d = line_q + 1'b1;
                  dir_d  = 1'b0;
                end else begin
                  for (int i = 0; i < ROWS; i++) rows_d[i] = rows_q[i] >> 1;
                end
              end
            end
          end
        end
      end
      default: begin
        // IDLE, CLEARED and LANDED all restart the wave on start
        if (start) begin
          state_d = S_MARCH;
          for (int i = 0; i < ROWS; i++) rows_d[i] = ROW_INIT;
          line_d    = YW'(1);
          dir_d     = 1'b0;
          cnt_d     = '0;
          pend_d    = 1'b0;
          hit_row_d = '0;
        end
      end
    endcase
  end

  // state registers with synchronous reset taking priority over everything
  always_ff @(posedge clk_36MHz) begin
    if (reset) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < ROWS; i++) rows_q[i] <= ROW_INIT;
      line_q    <= YW'(1);
      dir_q     <= 1'b0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      hit_q     <= 1'b0;
      hit_row_q <= '0;
    end else begin
      state_q   <= state_d;
      for (int i = 0; i < ROWS; i++) rows_q[i] <= rows_d[i];
      line_q    <= line_d;
      dir_q     <= dir_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      hit_q     <= hit_d;
      hit_row_q <= hit_row_d;
    end
  end

  assign hit           = hit_q;
  assign hit_row       = hit_row_q;
  assign invaders_line = line_q;
  assign cleared       = (state_q == S_CLEARED);
  assign landed        = (state_q == S_LANDED);

endmodule

// File: tb/tb_invader_formation.sv
// Bench for invader_formation: per-cycle scoreboard against a behavioural
// model, directed constant checks, and a step-period measurement on a second
// instance (expects 4 cycles with INVADER_SPEEDUP_EN, 16 without).
module tb_invader_formation;

  localparam int COLS = 20;
  localparam int ROWS = 2;
  localparam int TICKS = 4;
  localparam int BL = 14;
`ifdef INVADER_SPEEDUP_EN
  localparam int EXP_P2 = 4;
`else
  localparam int EXP_P2 = 16;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, st = 1'b0, bv = 1'b0;
  logic [4:0]  bx = '0;
  logic [3:0]  by = '0;
  logic [2:0]  lvl = 3'd0;
  logic        hit, cleared, landed;
  logic [0:0]  hit_row;
  logic [39:0] arr;
  logic [3:0]  line;

  logic        st2 = 1'b0;
  logic [2:0]  lvl2 = 3'd2;
  logic        s_hit, s_cleared, s_landed;
  logic [0:0]  s_hit_row;
  logic [39:0] s_arr;
  logic [3:0]  s_line;

  invader_formation #(.COLS(COLS), .ROWS(ROWS), .STEP_TICKS(TICKS), .BOTTOM_LINE(BL),
                      .XW(5), .YW(4)) dut (
    .clk_36MHz(clk), .reset(rst), .start(st), .bullet_valid(bv), .bullet_x(bx),
    .bullet_y(by), .level(lvl), .hit(hit), .hit_row(hit_row), .invaders_array(arr),
    .invaders_line(line), .cleared(cleared), .landed(landed));

  invader_formation #(.COLS(COLS), .ROWS(ROWS), .STEP_TICKS(16), .BOTTOM_LINE(BL),
                      .XW(5), .YW(4)) dut_s (
    .clk_36MHz(clk), .reset(rst), .start(st2), .bullet_valid(1'b0), .bullet_x(5'd0),
    .bullet_y(4'd0), .level(lvl2), .hit(s_hit), .hit_row(s_hit_row),
    .invaders_array(s_arr), .invaders_line(s_line), .cleared(s_cleared),
    .landed(s_landed));

  int n_total = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // behavioural model: 0 idle, 1 march, 2 cleared, 3 landed
  int          m_st;
  logic [19:0] m_rows [ROWS];
  int          m_line;
  bit          m_right;
  int          m_cnt;
  bit          m_pend;
  bit          m_hit;
  int          m_hitrow;

  logic [47:0] exp_q [$];

  task automatic m_init();
    for (int r = 0; r < ROWS; r++) m_rows[r] = 20'h003FF;
    m_line = 1; m_right = 0; m_cnt = 0; m_pend = 0; m_hitrow = 0;
  endtask

  task automatic model(input bit r, input bit s, input bit v, input int x, input int y);
    int  tgt;
    bit  want;
    bit  any_l, any_r, none;
    m_hit = 0;
    if (r) begin
      m_init(); m_st = 0;
    end else if (m_st == 1) begin
      none = 1;
      for (int i = 0; i < ROWS; i++) if (m_rows[i] != 0) none = 0;
      if (none) m_st = 2;
      else if (m_line + ROWS - 1 >= BL) m_st = 3;
      else begin
        want = (m_cnt == TICKS - 1) || m_pend;
        m_cnt = (m_cnt == TICKS - 1) ? 0 : m_cnt + 1;
        tgt = -1;
        if (v && x < COLS)
          for (int i = 0; i < ROWS; i++)
            if (tgt < 0 && y == m_line + i + 1 && m_rows[i][x]) tgt = i;
        if (tgt >= 0) begin
          m_rows[tgt][x] = 1'b0;
          m_hit = 1; m_hitrow = tgt; m_pend = want;
        end else begin
          m_pend = 0;
          if (want) begin
            any_l = 0; any_r = 0;
            for (int i = 0; i < ROWS; i++) begin
              any_l |= m_rows[i][19];
              any_r |= m_rows[i][0];
            end
            if (!m_right && any_l) begin m_line++; m_right = 1; end
            else if (m_right && any_r) begin m_line++; m_right = 0; end
            else for (int i = 0; i < ROWS; i++)
              m_rows[i] = m_right ? (m_rows[i] >> 1) : (m_rows[i] << 1);
          end
        end
      end
    end else if (s) begin
      m_init(); m_st = 1;
    end
  endtask

  // one clock: drive inputs, queue the model's expectation, compare after the edge
  task automatic cyc(input bit r, input bit s, input bit v, input int x, input int y);
    logic [47:0] got, exp;
    rst = r; st = s; bv = v; bx = 5'(x); by = 4'(y);
    model(r, s, v, x, y);
    exp_q.push_back({(m_st == 2), (m_st == 3), m_hit, 1'(m_hitrow), 4'(m_line),
                     m_rows[1], m_rows[0]});
    @(posedge clk); #1;
    got = {cleared, landed, hit, hit_row, line, arr};
    exp = exp_q.pop_front();
    check("scoreboard", 64'(got), 64'(exp));
    if (v) $display("bullet x=%0d y=%0d -> hit=%0d row=%0d", x, y, hit, hit_row);
    rst = 0; st = 0; bv = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  initial begin
    int tx, ty, guard, cnt;
    m_init(); m_st = 0; m_hit = 0;

    // reset state
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("rst_array", 64'(arr), 64'h003FF_003FF);
    check("rst_flags", 64'({hit, hit_row, cleared, landed, line}), 64'({4'b0000, 4'd1}));
    idle(3);

    // first step after four cycles, then march to the left wall and bounce
    cyc(0, 1, 0, 0, 0);
    idle(4);
    check("first_step", 64'(arr), 64'h007FE_007FE);
    check("first_line", 64'(line), 64'd1);
    idle(36);
    check("at_wall", 64'(arr), 64'hFFC00_FFC00);
    idle(4);
    check("descend_arr", 64'(arr), 64'hFFC00_FFC00);
    check("descend_line", 64'(line), 64'd2);
    idle(4);
    check("shift_right", 64'(arr), 64'h7FE00_7FE00);

    // hits, repeated bullet, out-of-range column, hit coincident with step
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 0, 1, 3, 2);
    check("hit_pulse", 64'({hit, hit_row}), 64'({1'b1, 1'b0}));
    check("hit_bit3", 64'(arr[3]), 64'd0);
    cyc(0, 0, 1, 3, 2);
    check("rehit_none", 64'(hit), 64'd0);
    cyc(0, 0, 1, 25, 2);
    check("x_oob_none", 64'(hit), 64'd0);
    idle(4);
    cyc(0, 0, 1, 5, 2);
    check("coinc_hit", 64'({hit, arr}), {23'd0, 1'b1, 40'h007FE_007CE});
    idle(1);
    check("coinc_step", 64'(arr), 64'h00FFC_00F9C);
    cyc(0, 0, 1, 2, 3);
    check("hit_row1", 64'({hit, hit_row}), 64'({1'b1, 1'b1}));

    // shoot down every remaining invader, aiming with the model's grid
    guard = 0;
    while (m_st != 2 && guard < 200) begin
      tx = -1; ty = 0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (tx < 0 && m_rows[r][c]) begin tx = c; ty = m_line + r + 1; end
      if (tx < 0) cyc(0, 0, 0, 0, 0); else cyc(0, 0, 1, tx, ty);
      guard++;
    end
    check("cleared_flag", 64'({cleared, landed}), 64'b10);
    cyc(0, 0, 1, 0, 2);
    check("cleared_nohit", 64'(hit), 64'd0);

    // restart from CLEARED and let the wave land
    cyc(0, 1, 0, 0, 0);
    check("restart", 64'({cleared, line, arr}), {19'd0, 1'b0, 4'd1, 40'h003FF_003FF});
    guard = 0;
    while (m_st != 3 && guard < 1500) begin
      cyc(0, 0, 0, 0, 0);
      guard++;
    end
    check("landed_flag", 64'({cleared, landed}), 64'b01);
    check("landed_line", 64'(line), 64'd13);
    cyc(0, 1, 0, 0, 0);
    check("restart_land", 64'({landed, line}), 64'({1'b0, 4'd1}));

    // step period of the second instance at level 2
    st2 = 1'b1; @(posedge clk); #1; st2 = 1'b0;
    cnt = 0;
    while (s_arr == 40'h003FF_003FF && cnt < 40) begin @(posedge clk); #1; cnt++; end
    check("period_first", 64'(cnt), 64'(EXP_P2));
    cnt = 0;
    while (s_arr == 40'h007FE_007FE && cnt < 40) begin @(posedge clk); #1; cnt++; end
    check("period_next", 64'(cnt), 64'(EXP_P2));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
